// File: rtl/mem_stage_pkg.sv
// Shared load-size encodings and lane-width helpers for the memory stage
// and anything else that slices data-memory words.
package mem_stage_pkg;

    localparam logic [1:0] LD_SIZE_B = 2'd0;
    localparam logic [1:0] LD_SIZE_H = 2'd1;
    localparam logic [1:0] LD_SIZE_W = 2'd2;
    localparam logic [1:0] LD_SIZE_D = 2'd3;

    // Number of address bits that select a byte lane inside a data word.
    function automatic int lane_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane mux: picks the size-aligned byte/half/word/dword out of
// a memory word and zero- or sign-extends it to the full data width.
module load_extract
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = lane_w(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [LANE_W-1:0] lane,
    input  logic [1:0]        size,
    input  logic              sign,
    output logic [DATA_W-1:0] result
);

    logic [LANE_W-1:0] aligned;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              sign_bit;

    always_comb begin
        aligned  = lane;
        mask     = '1;
        sign_bit = 1'b0;
        // Address bits below the access size are dropped, not trapped here.
        case (size)
            LD_SIZE_H: aligned[0]   = 1'b0;
            LD_SIZE_W: aligned[1:0] = 2'b00;
            LD_SIZE_D: aligned      = '0;
            default:   aligned      = lane;
        endcase
        shifted = data >> {aligned, 3'b000};
        case (size)
            LD_SIZE_B: begin
                mask     = DATA_W'(8'hFF);
                sign_bit = shifted[7];
            end
            LD_SIZE_H: begin
                mask     = DATA_W'(16'hFFFF);
                sign_bit = shifted[15];
            end
            LD_SIZE_W: begin
                mask     = DATA_W'(32'hFFFF_FFFF);
                sign_bit = shifted[31];
            end
            default: begin
                mask     = '1;
                sign_bit = shifted[DATA_W-1];
            end
        endcase
        result = shifted & mask;
        if (sign && sign_bit) begin
            result = result | ~mask;
        end
    end

endmodule

// File: rtl/mem_resp_stage.sv
// MEM pipeline stage with variable-latency data-memory responses: stalls on
// outstanding loads, buffers a response under WB back-pressure, drops stale
// responses of flushed loads and forwards its result to ID.
module mem_resp_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MAX_DISCARD = 3,
    parameter int PC_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_is_load,
    input  logic              in_req_sent,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_sign,
    input  logic              in_rf_we,
    input  logic [4:0]        in_rf_waddr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              mem_allow_in,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,
    input  logic              flush,
    input  logic              wb_allow_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic              out_rf_we,
    output logic [4:0]        out_rf_waddr,
    output logic [PC_W-1:0]   out_pc,
    output logic              byp_we,
    output logic [4:0]        byp_waddr,
    output logic              byp_data_ok,
    output logic [DATA_W-1:0] byp_data
);

    localparam int LANE_W = lane_w(DATA_W);
    localparam int CNT_W  = $clog2(MAX_DISCARD + 1);

    // Handshakes are valid/ready: an instruction enters on in_valid & mem_allow_in
    // and leaves to WB on out_valid & wb_allow_in, both at the rising edge.
    logic              stage_valid;
    logic [DATA_W-1:0] r_result;
    logic              r_is_load;
    logic              r_req_sent;
    logic [1:0]        r_ld_size;
    logic              r_ld_sign;
    logic              r_rf_we;
    logic [4:0]        r_rf_waddr;
    logic [PC_W-1:0]   r_pc;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;
    logic [CNT_W-1:0]  discard_cnt;

    logic              resp_live;
    logic              wait_load;
    logic              ready_go;
    logic              handoff;
    logic              disc_inc;
    logic              disc_dec;
    logic [DATA_W-1:0] load_src;
    logic [DATA_W-1:0] extracted;

    assign resp_live    = data_ok && (discard_cnt == '0);
    assign wait_load    = stage_valid && r_is_load && r_req_sent;
    assign ready_go     = !wait_load || buf_valid || resp_live;
    assign mem_allow_in = (!stage_valid || (ready_go && wb_allow_in))
                          && (discard_cnt < CNT_W'(MAX_DISCARD)) && !flush;
    assign out_valid    = stage_valid && ready_go && !flush;
    assign handoff      = out_valid && wb_allow_in;

    // A flushed load whose response has not yet been seen leaves one stale
    // response in flight; a simultaneous drop nets out to no change.
    assign disc_inc = flush && wait_load && !buf_valid && !resp_live;
    assign disc_dec = data_ok && (discard_cnt != '0);

    assign load_src = buf_valid ? buf_data : rdata;

    load_extract #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_extract (
        .data   (load_src),
        .lane   (r_result[LANE_W-1:0]),
        .size   (r_ld_size),
        .sign   (r_ld_sign),
        .result (extracted)
    );

    assign out_result   = r_is_load ? extracted : r_result;
    assign out_rf_we    = r_rf_we;
    assign out_rf_waddr = r_rf_waddr;
    assign out_pc       = r_pc;
    assign byp_we       = stage_valid && r_rf_we;
    assign byp_waddr    = r_rf_waddr;
    assign byp_data_ok  = ready_go;
    assign byp_data     = out_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= 1'b0;
        end else if (flush) begin
            stage_valid <= 1'b0;
        end else if (in_valid && mem_allow_in) begin
            stage_valid <= 1'b1;
        end else if (handoff) begin
            stage_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && mem_allow_in) begin
            r_result   <= in_result;
            r_is_load  <= in_is_load;
            r_req_sent <= in_req_sent;
            r_ld_size  <= in_ld_size;
            r_ld_sign  <= in_ld_sign;
            r_rf_we    <= in_rf_we;
            r_rf_waddr <= in_rf_waddr;
            r_pc       <= in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
        end else if (flush || handoff) begin
            buf_valid <= 1'b0;
        end else if (resp_live && wait_load && !buf_valid && !wb_allow_in) begin
            buf_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resp_live && wait_load && !buf_valid && !wb_allow_in) begin
            buf_data <= rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= '0;
        end else begin
            discard_cnt <= discard_cnt + CNT_W'(disc_inc) - CNT_W'(disc_dec);
        end
    end

endmodule

// File: doc/mem_resp_stage.md
Name: mem_resp_stage

Overview:
- Parametrised successor to the single-cycle MEM stage: owns the EX->MEM pipeline register and accepts data-memory responses that arrive any number of cycles after the request (req/data_ok style).
- Stalls until a load's data returns, and buffers the response if WB back-pressures.
- Drops the stale responses of flushed loads.
- Performs lane extraction and sign extension for DATA_W of 32 or 64, and drives the WB payload and the bypass bus.

Parameters:
- DATA_W, 32, data path and SRAM data width; legal values 32 or 64.
- MAX_DISCARD, 3, maximum outstanding responses of flushed loads that can be tracked for dropping.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  EX holds a valid instruction.
- in_result  in  DATA_W  EX result; the load address when in_is_load=1.
- in_is_load  in  1  instruction is a load.
- in_req_sent  in  1  the load's memory request was accepted in EX.
- in_ld_size  in  2  0=byte, 1=half, 2=word, 3=dword (dword is legal only when DATA_W=64).
- in_ld_sign  in  1  sign-extend the loaded value.
- in_rf_we  in  1  instruction writes the register file.
- in_rf_waddr  in  5  destination register.
- in_pc  in  PC_W  instruction PC.
- mem_allow_in  out  1  stage can accept an instruction this cycle.
- data_ok  in  1  memory response valid (single-cycle pulse; responses return in request order).
- rdata  in  DATA_W  response data.
- flush  in  1  kill the instruction held in the stage (exception/ertn).
- wb_allow_in  in  1  WB accepts this cycle.
- out_valid  out  1  WB payload valid.
- out_result  out  DATA_W  final writeback value.
- out_rf_we  out  1  register write enable.
- out_rf_waddr  out  5  register write address.
- out_pc  out  PC_W  PC.
- byp_we  out  1  stage holds a valid register-writing instruction.
- byp_waddr  out  5  its destination register.
- byp_data_ok  out  1  byp_data is final; if 0, ID must stall on a match.
- byp_data  out  DATA_W  forwarded value.

Behaviour:
- State: stage_valid, payload register, buf_valid, buf_data, discard_cnt (width clog2(MAX_DISCARD+1)).
- Reset (synchronous, active-high): stage_valid=0, buf_valid=0, discard_cnt=0. Hence out_valid=0, byp_we=0, mem_allow_in=1.
- resp_live = data_ok & (discard_cnt==0).
- wait_load = stage_valid & in-stage is_load & req_sent.
- ready_go = !wait_load | buf_valid | resp_live.
- mem_allow_in = (!stage_valid | (ready_go & wb_allow_in)) & (discard_cnt < MAX_DISCARD) & !flush.
- Load: when in_valid & mem_allow_in, the payload is captured on the next edge and stage_valid=1. Otherwise stage_valid clears once out_valid & wb_allow_in.
- out_valid = stage_valid & ready_go & !flush.
- Stall-buffer: if resp_live & wait_load & !buf_valid & !wb_allow_in, then buf_data<=rdata and buf_valid<=1. buf_valid clears when the stage hands off to WB, or on flush.
- Load data source: buf_valid ? buf_data : rdata.
- Lane extraction uses lane = in-stage result[log2(DATA_W/8)-1:0], aligned to the access size. Low address bits below the size are ignored; misalignment is the exception unit's job.
- Extraction output is zero- or sign-extended to DATA_W per in_ld_sign.
- out_result = is_load ? extracted : result.
- Discard counting:
  - On flush, if wait_load & !buf_valid & !resp_live, discard_cnt increments (saturation is prevented by the mem_allow_in gate).
  - When data_ok & discard_cnt>0, discard_cnt decrements and the response is dropped.
  - If flush and data_ok occur together on a waiting load, the response belongs to the flushed load and discard_cnt is unchanged.
- Flush: stage_valid<=0 and buf_valid<=0 on the next edge. Same-cycle input is refused because mem_allow_in=0.
- Non-load instructions and loads with in_req_sent=0 pass through with zero-cycle stage latency (ready_go=1).
- Bypass:
  - byp_we = stage_valid & rf_we.
  - byp_data_ok = ready_go.
  - byp_data = out_result.

Decomposition:
- Package mem_stage_pkg holds the LD_SIZE_{B,H,W,D} constants and the lane-width localparam helpers.
- Sub-module load_extract (combinational; inputs data, lane, size, sign) holds the lane mux. It is reused by a future store-merge path.

Test Plan:
- Non-load add: result=0x1234, wb_allow_in=1 -> out_valid next cycle with out_result=0x1234; mem_allow_in stays 1.
- ld.b signed, addr low bits=2'b11, rdata=0x80FF_0000 arrives 3 cycles late -> stall 3 cycles (byp_data_ok=0); then out_result=0xFFFF_FF80.
- ld.hu, data_ok arrives while wb_allow_in=0 -> buf_valid=1. rdata then changes to garbage; when WB is allowed 2 cycles later, out_result=zero-extended original halfword.
- Flush a waiting load, then a new ld.w enters; the next data_ok=0xDEAD is dropped (discard_cnt 1->0) and the following data_ok=0xBEEF -> out_result=0xBEEF.
- Three back-to-back flushed waiting loads with MAX_DISCARD=3 -> mem_allow_in=0 until the first data_ok returns.
- DATA_W=64, ld.d at addr 0x8 with sign=1 -> full 64-bit rdata passed through; ld.w at addr 0x4 -> upper word of rdata, sign-extended.
